// File: rtl/idli_decq_m.sv
// idli_decq_m: decode queue between the SQI fetch path and the decoder.
// Serial slices are assembled into WORD_W-bit words, tagged as instruction
// or trailing immediate, and buffered in a DEPTH-entry FIFO that the decoder
// drains with a valid/ready handshake. Flush discards queued and partial words.
//
// Optional feature macro: IDLI_DECQ_BYPASS_EN
//   defined   - a word completing into an empty queue is presented in the
//               same cycle as its final slice (consumed without a write if
//               the decoder is ready).
//   undefined - outputs come from queue storage only; one cycle of latency.
//
// Tag state machine
//   state    | meaning
//   EXP_INSN | next completed word is an instruction
//   EXP_IMM  | next completed word is the immediate of the previous instruction

module idli_decq_m #(
    parameter int DEPTH   = 2,
    parameter int SLICE_W = 4,
    parameter int WORD_W  = 16
) (
    input  logic                         i_dq_gck,
    input  logic                         i_dq_rst_n,
    input  logic [SLICE_W-1:0]           i_dq_slice,
    input  logic                         i_dq_slice_vld,
    output logic                         o_dq_slice_rdy,
    input  logic                         i_dq_flush,
    output logic                         o_dq_vld,
    input  logic                         i_dq_rdy,
    output logic [WORD_W-1:0]            o_dq_enc,
    output logic                         o_dq_imm,
    output logic                         o_dq_has_imm,
    output logic [$clog2(DEPTH+1)-1:0]   o_dq_count
);

    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int SHW    = WORD_W - SLICE_W;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [SW-1:0] SCTR_LAST = SW'(NSLICE - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic {
        EXP_INSN = 1'b0,
        EXP_IMM  = 1'b1
    } tag_state_t;

    tag_state_t          r_state;
    tag_state_t          w_state_nxt;
    logic [SW-1:0]       r_sctr;
    logic [SHW-1:0]      r_shift;
    logic [CW-1:0]       r_wptr;
    logic [CW-1:0]       r_rptr;
    logic [WORD_W-1:0]   r_mem_enc  [DEPTH];
    logic                r_mem_imm  [DEPTH];
    logic                r_mem_himm [DEPTH];

    logic [CW-1:0]       w_count;
    logic                w_nempty;
    logic                w_full;
    logic                w_qpop;
    logic                w_pop;
    logic                w_slice_rdy;
    logic                w_slice_acc;
    logic                w_final;
    logic                w_push;
    logic                w_byp_take;
    logic [WORD_W-1:0]   w_word;
    logic [3:0]          w_op4;
    logic                w_opc_noimm;
    logic                w_tag_imm;
    logic                w_tag_himm;

    assign w_count  = r_wptr - r_rptr;
    assign w_nempty = (w_count != '0);
    assign w_full   = (w_count == CNT_FULL);
    // Queue pop only; bypass consumption never frees a slot, so it stays out
    // of the slice-ready path and avoids a combinational loop.
    assign w_qpop   = w_nempty && i_dq_rdy;
    assign w_pop    = w_qpop && !i_dq_flush;

    assign w_slice_rdy = !i_dq_flush && ((r_sctr != SCTR_LAST) || !w_full || w_qpop);
    assign w_slice_acc = i_dq_slice_vld && w_slice_rdy;
    assign w_final     = w_slice_acc && (r_sctr == SCTR_LAST);
    assign w_word      = {r_shift, i_dq_slice};

    // Opcodes 100x, 1101 and 1010 never carry a trailing immediate.
    assign w_op4       = w_word[WORD_W-1 -: 4];
    assign w_opc_noimm = (w_op4[3:1] == 3'b100) || (w_op4 == 4'b1101) || (w_op4 == 4'b1010);

    assign o_dq_slice_rdy = w_slice_rdy;
    assign o_dq_count     = w_count;

`ifdef IDLI_DECQ_BYPASS_EN
    logic w_byp_vld;
    assign w_byp_vld    = !w_nempty && w_final;
    assign w_byp_take   = w_byp_vld && i_dq_rdy;
    assign o_dq_vld     = w_nempty || w_byp_vld;
    assign o_dq_enc     = w_byp_vld ? w_word     : r_mem_enc[r_rptr[PW-1:0]];
    assign o_dq_imm     = w_byp_vld ? w_tag_imm  : r_mem_imm[r_rptr[PW-1:0]];
    assign o_dq_has_imm = w_byp_vld ? w_tag_himm : r_mem_himm[r_rptr[PW-1:0]];
`else
    assign w_byp_take   = 1'b0;
    assign o_dq_vld     = w_nempty;
    assign o_dq_enc     = r_mem_enc[r_rptr[PW-1:0]];
    assign o_dq_imm     = r_mem_imm[r_rptr[PW-1:0]];
    assign o_dq_has_imm = r_mem_himm[r_rptr[PW-1:0]];
`endif

    assign w_push = w_final && !w_byp_take;

    // Tag state register.
    always_ff @(posedge i_dq_gck) begin
        if (!i_dq_rst_n) begin
            r_state <= EXP_INSN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tag next-state and the live tags of the word completing this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tag_imm   = 1'b0;
        w_tag_himm  = 1'b0;
        case (r_state)
            EXP_INSN: begin
                w_tag_himm = (&i_dq_slice) && !w_opc_noimm;
                if (w_final && w_tag_himm) begin
                    w_state_nxt = EXP_IMM;
                end
            end
            EXP_IMM: begin
                w_tag_imm = 1'b1;
                if (w_final) begin
                    w_state_nxt = EXP_INSN;
                end
            end
        endcase
        if (i_dq_flush) begin
            w_state_nxt = EXP_INSN;
        end
    end

    // Slice assembly, queue storage and pointers.
    always_ff @(posedge i_dq_gck) begin
        if (!i_dq_rst_n) begin
            r_sctr  <= '0;
            r_shift <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_enc[i]  <= '0;
                r_mem_imm[i]  <= 1'b0;
                r_mem_himm[i] <= 1'b0;
            end
        end else if (i_dq_flush) begin
            r_sctr  <= '0;
            r_shift <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_slice_acc) begin
                r_sctr  <= (r_sctr == SCTR_LAST) ? '0 : r_sctr + 1'b1;
                r_shift <= w_word[SHW-1:0];
            end
            if (w_push) begin
                r_mem_enc[r_wptr[PW-1:0]]  <= w_word;
                r_mem_imm[r_wptr[PW-1:0]]  <= w_tag_imm;
                r_mem_himm[r_wptr[PW-1:0]] <= w_tag_himm;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idli_decq_m.sv
// Bench for idli_decq_m (DEPTH=2, SLICE_W=4, WORD_W=16): a table of words
// with hand-computed tags plus directed sequences for full, flush and reset.
module tb_idli_decq_m;

    logic        clk;
    logic        rst_n;
    logic [3:0]  slice;
    logic        slice_vld;
    logic        slice_rdy;
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [15:0] enc;
    logic        imm;
    logic        has_imm;
    logic [1:0]  count;

    int checks;
    int failures;

    idli_decq_m #(.DEPTH(2), .SLICE_W(4), .WORD_W(16)) dut (
        .i_dq_gck       (clk),
        .i_dq_rst_n     (rst_n),
        .i_dq_slice     (slice),
        .i_dq_slice_vld (slice_vld),
        .o_dq_slice_rdy (slice_rdy),
        .i_dq_flush     (flush),
        .o_dq_vld       (vld),
        .i_dq_rdy       (rdy),
        .o_dq_enc       (enc),
        .o_dq_imm       (imm),
        .o_dq_has_imm   (has_imm),
        .o_dq_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        imm;
        logic        has_imm;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Four slices on consecutive cycles, then idle; returns #1 after the
    // negedge following the final slice.
    task automatic feed_word(input logic [15:0] w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            slice_vld = 1'b1;
            slice     = w[15-4*k -: 4];
        end
        @(negedge clk);
        slice_vld = 1'b0;
        #1;
    endtask

    task automatic pop_one();
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] w;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        slice     = '0;
        slice_vld = 1'b0;
        flush     = 1'b0;
        rdy       = 1'b0;

        tbl[0]  = '{16'h2134, 1'b0, 1'b0};
        tbl[1]  = '{16'h013F, 1'b0, 1'b1};
        tbl[2]  = '{16'hBEEF, 1'b1, 1'b0};
        tbl[3]  = '{16'h2134, 1'b0, 1'b0};
        tbl[4]  = '{16'h801F, 1'b0, 1'b0};
        tbl[5]  = '{16'h2134, 1'b0, 1'b0};
        tbl[6]  = '{16'hD00F, 1'b0, 1'b0};
        tbl[7]  = '{16'hA00F, 1'b0, 1'b0};
        tbl[8]  = '{16'h900F, 1'b0, 1'b0};
        tbl[9]  = '{16'h300F, 1'b0, 1'b1};
        tbl[10] = '{16'h300F, 1'b1, 1'b0};
        tbl[11] = '{16'hFFFF, 1'b0, 1'b1};
        tbl[12] = '{16'hFFFF, 1'b1, 1'b0};
        tbl[13] = '{16'h7FF0, 1'b0, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_vld", 32'(vld), 32'h0);
        check("rst_enc", 32'(enc), 32'h0);
        check("rst_imm", 32'(imm), 32'h0);
        check("rst_has_imm", 32'(has_imm), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_slice_rdy", 32'(slice_rdy), 32'h1);

        // Basic word with an always-ready consumer
        rdy = 1'b1;
        w = 16'h2134;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            slice_vld = 1'b1;
            slice     = w[15-4*k -: 4];
        end
        @(negedge clk);
        slice = w[3:0];
        #1;
`ifdef IDLI_DECQ_BYPASS_EN
        check("byp_vld_same", 32'(vld), 32'h1);
        check("byp_enc_same", 32'(enc), 32'h2134);
        check("byp_imm_same", 32'(imm), 32'h0);
`else
        check("nobyp_vld_same", 32'(vld), 32'h0);
`endif
        @(negedge clk);
        slice_vld = 1'b0;
        #1;
`ifdef IDLI_DECQ_BYPASS_EN
        check("byp_vld_next", 32'(vld), 32'h0);
        check("byp_count_next", 32'(count), 32'h0);
`else
        check("first_vld", 32'(vld), 32'h1);
        check("first_enc", 32'(enc), 32'h2134);
        check("first_imm", 32'(imm), 32'h0);
        check("first_has_imm", 32'(has_imm), 32'h0);
        check("first_count", 32'(count), 32'h1);
`endif
        @(negedge clk);
        #1;
        check("first_drain_count", 32'(count), 32'h0);
        check("first_drain_vld", 32'(vld), 32'h0);
        rdy = 1'b0;

        // Tagging table, one word at a time with a stalled consumer
        for (int i = 0; i < 14; i++) begin
            feed_word(tbl[i].word);
            check($sformatf("tbl%0d_vld", i), 32'(vld), 32'h1);
            check($sformatf("tbl%0d_enc", i), 32'(enc), 32'(tbl[i].word));
            check($sformatf("tbl%0d_imm", i), 32'(imm), 32'(tbl[i].imm));
            check($sformatf("tbl%0d_has_imm", i), 32'(has_imm), 32'(tbl[i].has_imm));
            check($sformatf("tbl%0d_count", i), 32'(count), 32'h1);
            pop_one();
            check($sformatf("tbl%0d_pop_count", i), 32'(count), 32'h0);
        end

        // Fill to DEPTH, back-pressure on the final slice, then push+pop
        feed_word(16'h1111);
        feed_word(16'h2222);
        check("full_count", 32'(count), 32'h2);
        w = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            slice_vld = 1'b1;
            slice     = w[15-4*k -: 4];
        end
        @(negedge clk);
        slice = w[3:0];
        #1;
        check("full_slice_rdy", 32'(slice_rdy), 32'h0);
        @(negedge clk);
        #1;
        check("full_hold_slice_rdy", 32'(slice_rdy), 32'h0);
        check("full_hold_count", 32'(count), 32'h2);
        check("full_hold_enc", 32'(enc), 32'h1111);
        rdy = 1'b1;
        #1;
        check("full_pop_slice_rdy", 32'(slice_rdy), 32'h1);
        @(negedge clk);
        slice_vld = 1'b0;
        rdy       = 1'b0;
        #1;
        check("pushpop_count", 32'(count), 32'h2);
        check("pushpop_enc", 32'(enc), 32'h2222);
        rdy = 1'b1;
        @(negedge clk);
        #1;
        check("drain_enc", 32'(enc), 32'h3333);
        check("drain_count", 32'(count), 32'h1);
        @(negedge clk);
        rdy = 1'b0;
        #1;
        check("drain_empty_count", 32'(count), 32'h0);

        // Pop request on an empty queue is ignored
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("empty_pop_count", 32'(count), 32'h0);
        check("empty_pop_vld", 32'(vld), 32'h0);
        rdy = 1'b0;

        // Flush mid-word with one entry queued and an immediate expected
        feed_word(16'h013F);
        check("flush_pre_has_imm", 32'(has_imm), 32'h1);
        @(negedge clk);
        slice_vld = 1'b1;
        slice     = 4'hB;
        @(negedge clk);
        slice     = 4'hE;
        @(negedge clk);
        slice     = 4'hE;
        flush     = 1'b1;
        #1;
        check("flush_slice_rdy", 32'(slice_rdy), 32'h0);
        @(negedge clk);
        flush     = 1'b0;
        slice_vld = 1'b0;
        #1;
        check("flush_count", 32'(count), 32'h0);
        check("flush_vld", 32'(vld), 32'h0);
        feed_word(16'h2134);
        check("post_flush_enc", 32'(enc), 32'h2134);
        check("post_flush_imm", 32'(imm), 32'h0);
        check("post_flush_has_imm", 32'(has_imm), 32'h0);
        check("post_flush_count", 32'(count), 32'h1);
        pop_one();

        // Reset mid-word while an immediate is expected
        feed_word(16'h013F);
        @(negedge clk);
        slice_vld = 1'b1;
        slice     = 4'h5;
        @(negedge clk);
        slice     = 4'h5;
        @(negedge clk);
        slice_vld = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_vld", 32'(vld), 32'h0);
        check("midrst_enc", 32'(enc), 32'h0);
        feed_word(16'h2134);
        check("post_rst_enc", 32'(enc), 32'h2134);
        check("post_rst_imm", 32'(imm), 32'h0);
        check("post_rst_count", 32'(count), 32'h1);
        pop_one();
        check("post_rst_pop_count", 32'(count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
